mux_scan: RTL

Parametrised, registered N:1 channel selector with a valid/ready output and an auto-scan mode. It generalises the combinational 8:1 select to W-bit channels and N inputs. In manual mode it samples the channel named by `sel`. In scan mode it walks all channels itself, dwelling a fixed number of cycles on each. It sits between a bank of sampled status/data lines and a single downstream consumer that may stall.

---
 rtl/mux_scan_pkg.sv | 13 +
 rtl/mux_scan_pick.sv | 37 +++
 rtl/mux_scan.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan shared definitions: FSM state codes
// and the index-width helper.
package mux_scan_pkg;

  localparam logic [1:0] S_MAN   = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_pick.sv
// Next enabled channel strictly after ptr_i, wrapping;
// ptr_i itself when it is the only enabled one.
module mux_scan_pick
  import mux_scan_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = idx_w(N)
) (
  input  logic [SW-1:0] ptr_i,
  input  logic [N-1:0]  ch_en_i,
  output logic [SW-1:0] nxt_o,
  output logic          any_o
);

  logic [SW-1:0] up_c;
  logic [SW-1:0] lo_c;
  logic          up_hit;

  always_comb begin
    up_c   = ptr_i;
    lo_c   = ptr_i;
    up_hit = 1'b0;
    for (int c = N - 1; c >= 0; c--) begin
      if (ch_en_i[c]) begin
        lo_c = SW'(c);
        if (SW'(c) > ptr_i) begin
          up_c   = SW'(c);
          up_hit = 1'b1;
        end
      end
    end
    nxt_o = up_hit ? up_c : lo_c;
  end

  assign any_o = |ch_en_i;

endmodule

// File: rtl/mux_scan.sv
// Registered N:1 channel selector with auto-scan.
// Define MUX_SCAN_MASK_EN for the ch_en scan mask.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  localparam int SW    = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0] sel,
  input  logic          mode,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]  ch_en,
`endif
  output logic [W-1:0]  out,
  output logic [SW-1:0] out_ch,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int CW = idx_w(DWELL);

  logic [1:0]    st_q, st_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_q, out_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          vld_q, vld_d;

  logic          free;
  logic          cap;
  logic [SW-1:0] cap_ch;
  logic [W-1:0]  samp;
  logic [SW-1:0] ptr_nxt;
  logic [SW-1:0] ptr_first;

  assign free = !vld_q || out_ready;

`ifdef MUX_SCAN_MASK_EN
  logic [SW-1:0] pk_in;
  logic          pk_any;

  // From N-1 the finder wraps to the lowest enabled channel
  assign pk_in = (st_q == S_MAN) ? SW'(N - 1) : ptr_q;

  mux_scan_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .ptr_i   (pk_in),
    .ch_en_i (ch_en),
    .nxt_o   (ptr_nxt),
    .any_o   (pk_any)
  );

  assign ptr_first = ptr_nxt;
`else
  assign ptr_nxt   = (ptr_q == SW'(N - 1)) ? '0
                   : ptr_q + 1'b1;
  assign ptr_first = '0;
`endif

  always_comb begin
    st_d   = st_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    cap    = 1'b0;
    cap_ch = sel;
    case (st_q)
      S_MAN: begin
        if (!mode) begin
          cap = free;
        end else begin
          ptr_d = ptr_first;
          cnt_d = '0;
          st_d  = S_DWELL;
        end
      end
      S_DWELL: begin
        if (!mode) begin
          st_d = S_MAN;
        end else if (cnt_q == CW'(DWELL - 1)) begin
          st_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        cap_ch = ptr_q;
        if (!mode) begin
          st_d = S_MAN;
`ifdef MUX_SCAN_MASK_EN
        end else if (!pk_any) begin
          st_d = S_EMIT;
        end else if (!ch_en[ptr_q]) begin
          ptr_d = ptr_nxt;
`endif
        end else if (free) begin
          cap   = 1'b1;
          ptr_d = ptr_nxt;
          cnt_d = '0;
          st_d  = S_DWELL;
        end
      end
      default: st_d = S_MAN;
    endcase
  end

  // Out-of-range select reads as zero
  always_comb begin
    samp = '0;
    for (int c = 0; c < N; c++) begin
      if (cap_ch == SW'(c)) samp = in[c*W +: W];
    end
  end

  always_comb begin
    out_d = out_q;
    ch_d  = ch_q;
    vld_d = vld_q && !out_ready;
    if (cap) begin
      out_d = samp;
      ch_d  = cap_ch;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= S_MAN;
      ptr_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      ch_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      ch_q  <= ch_d;
      vld_q <= vld_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = ch_q;
  assign out_valid = vld_q;

endmodule
